state_annunciator: RTL

STATE_ANNUNCIATOR -- requirements
Module: state_annunciator

---
 rtl/statedet_pkg.sv | 25 ++
 rtl/tick_gen.sv | 29 ++
 rtl/state_annunciator.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/statedet_pkg.sv
// Shared event codes for the state detector and annunciator.
// Also holds the annunciator FSM state type.
package statedet_pkg;

  localparam logic [2:0] ST_BUZZ = 3'b000;
  localparam logic [2:0] ST_ERR  = 3'b001;
  localparam logic [2:0] ST_ON   = 3'b010;
  localparam logic [2:0] ST_OFF  = 3'b011;
  localparam logic [2:0] ST_OPEN = 3'b100;

  typedef enum logic [2:0] {
    IDLE_PAT,
    BEEP_HI,
    BEEP_LO,
    DONE,
    ALARM
  } ann_st_e;

  function automatic logic code_valid(
    input logic [2:0] c
  );
    return c <= ST_OPEN;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Time-base divider: one-cycle tick every TICK_DIV clocks.
// clr restarts the count so a new pattern gets a full first tick.
module tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/state_annunciator.sv
// Turns the detector event code into buzzer and LED patterns.
// Code is registered once, then decoded into registered outputs.
module state_annunciator
  import statedet_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int BEEP_ON      = 100,
  parameter int BEEP_OFF     = 100,
  parameter int BLINK        = 250,
  parameter int OPEN_TIMEOUT = 30000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] state,
  output logic       buzzer,
  output logic       led_err,
  output logic       led_on,
  output logic       led_off,
  output logic       led_open,
  output logic       open_alarm,
  output logic       code_err
);

  localparam logic [15:0] HI_LAST  = 16'(BEEP_ON - 1);
  localparam logic [15:0] LO_LAST  = 16'(BEEP_OFF - 1);
  localparam logic [15:0] BLK_LAST = 16'(BLINK - 1);
  localparam logic [15:0] TO_LAST  = 16'(OPEN_TIMEOUT - 1);

  logic [2:0]  code_q;
  logic [2:0]  prev_q;
  logic [2:0]  act_q;
  ann_st_e     st_q;
  logic [1:0]  bcnt_q;
  logic [15:0] pat_q;
  logic [15:0] ph_q;
  logic [15:0] blk_q;
  logic        buz_q;
  logic        err_q;
  logic        on_q;
  logic        off_q;
  logic        opn_q;
  logic        alm_q;
  logic        cerr_q;
  logic        tick;
  logic        change;

  assign change = code_valid(code_q) && (code_q != act_q);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (change),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= ST_OFF;
      prev_q <= ST_OFF;
      cerr_q <= 1'b0;
    end else begin
      code_q <= state;
      prev_q <= code_q;
      cerr_q <= !code_valid(code_q) && (code_q != prev_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q  <= ST_OFF;
      st_q   <= IDLE_PAT;
      bcnt_q <= '0;
      pat_q  <= '0;
      ph_q   <= '0;
      blk_q  <= '0;
      buz_q  <= 1'b0;
      err_q  <= 1'b0;
      on_q   <= 1'b0;
      off_q  <= 1'b0;
      opn_q  <= 1'b0;
      alm_q  <= 1'b0;
    end else if (change) begin
      // Entry values land on the same edge as the code switch.
      act_q  <= code_q;
      bcnt_q <= '0;
      pat_q  <= '0;
      ph_q   <= '0;
      blk_q  <= '0;
      alm_q  <= 1'b0;
      err_q  <= (code_q == ST_ERR);
      on_q   <= (code_q == ST_ON);
      off_q  <= (code_q == ST_OFF);
      opn_q  <= (code_q == ST_OPEN);
      unique case (code_q)
        ST_BUZZ, ST_ERR, ST_ON: begin
          st_q  <= BEEP_HI;
          buz_q <= 1'b1;
        end
        default: begin
          st_q  <= IDLE_PAT;
          buz_q <= 1'b0;
        end
      endcase
    end else begin
      on_q  <= (act_q == ST_ON);
      off_q <= (act_q == ST_OFF);
      opn_q <= (act_q == ST_OPEN);
      if (act_q != ST_ERR) err_q <= 1'b0;
      if (tick) begin
        if (pat_q != 16'hFFFF) pat_q <= pat_q + 16'd1;
        if (act_q == ST_ERR) begin
          if (blk_q == BLK_LAST) begin
            blk_q <= '0;
            err_q <= ~err_q;
          end else begin
            blk_q <= blk_q + 16'd1;
          end
        end
        unique case (st_q)
          BEEP_HI: begin
            if (ph_q == HI_LAST) begin
              ph_q  <= '0;
              buz_q <= 1'b0;
              if (act_q == ST_BUZZ) begin
                st_q <= BEEP_LO;
              end else if (act_q == ST_ERR && bcnt_q != 2'd2) begin
                st_q   <= BEEP_LO;
                bcnt_q <= bcnt_q + 2'd1;
              end else begin
                st_q <= DONE;
              end
            end else begin
              ph_q <= ph_q + 16'd1;
            end
          end
          BEEP_LO: begin
            if (ph_q == LO_LAST) begin
              ph_q  <= '0;
              buz_q <= 1'b1;
              st_q  <= BEEP_HI;
            end else begin
              ph_q <= ph_q + 16'd1;
            end
          end
          IDLE_PAT: begin
            if (act_q == ST_OPEN && pat_q == TO_LAST) begin
              st_q  <= ALARM;
              alm_q <= 1'b1;
              buz_q <= 1'b1;
              ph_q  <= '0;
            end
          end
          ALARM: begin
            if (ph_q == (buz_q ? HI_LAST : LO_LAST)) begin
              ph_q  <= '0;
              buz_q <= ~buz_q;
            end else begin
              ph_q <= ph_q + 16'd1;
            end
          end
          DONE: begin
            st_q <= DONE;
          end
          default: begin
            st_q <= IDLE_PAT;
          end
        endcase
      end
    end
  end

  assign buzzer     = buz_q;
  assign led_err    = err_q;
  assign led_on     = on_q;
  assign led_off    = off_q;
  assign led_open   = opn_q;
  assign open_alarm = alm_q;
  assign code_err   = cerr_q;

endmodule
